// File: rtl/seq_mult_add_pkg.sv
// Shared types and width helpers for the seq_mult_add block.
// Holds the FSM state encoding and default operand widths.
package seq_mult_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam int QUOT_W_DEF = 8;
    localparam int DIV_W_DEF  = 16;

    function automatic int res_w(input int qw, input int dw);
        return qw + dw;
    endfunction

endpackage

// File: rtl/seq_mult_add_if.sv
// Operand/result handshake bundle for seq_mult_add.
// master = producer/consumer side, slave = the multiply-add block.
interface seq_mult_add_if
    import seq_mult_add_pkg::*;
#(
    parameter int QUOT_W = QUOT_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
);
    localparam int RES_W = res_w(QUOT_W, DIV_W);

    logic              in_valid;
    logic              in_ready;
    logic [QUOT_W-1:0] q;
    logic [DIV_W-1:0]  dvisor;
    logic [DIV_W-1:0]  r;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  res;
    logic              rem_ge_div;

    modport master (
        output in_valid, q, dvisor, r, out_ready,
        input  in_ready, out_valid, res, rem_ge_div
    );

    modport slave (
        input  in_valid, q, dvisor, r, out_ready,
        output in_ready, out_valid, res, rem_ge_div
    );

endinterface

// File: rtl/seq_mult_add_dp.sv
// Shift-add datapath: accumulator, multiplier shifter, step counter.
// SEQ_MULT_EARLY_EXIT_EN: last step when remaining multiplier bits are 0.
module seq_mult_add_dp #(
    parameter int QUOT_W = 8,
    parameter int DIV_W  = 16,
    parameter int RES_W  = QUOT_W + DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [QUOT_W-1:0] q,
    input  logic [DIV_W-1:0]  dvisor,
    input  logic [DIV_W-1:0]  r,
    output logic [RES_W-1:0]  acc,
    output logic              last
);

    logic [RES_W-1:0]  acc_q, acc_d;
    logic [RES_W-1:0]  mcand_q, mcand_d;
    logic [QUOT_W-1:0] mplier_q, mplier_d;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    // Done once the bits still to be consumed are all zero.
    assign last = ((mplier_q >> 1) == '0);
`else
    localparam int CNT_W = (QUOT_W > 1) ? $clog2(QUOT_W) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CNT_W'(QUOT_W - 1));

    // Step counter: cleared on load, advanced each busy cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign acc = acc_q;

    // Load operands, or add the shifted multiplicand per set multiplier bit.
    // mcand_q holds dvisor << cnt, so no barrel shifter is needed.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            acc_d    = {{QUOT_W{1'b0}}, r};
            mcand_d  = {{QUOT_W{1'b0}}, dvisor};
            mplier_d = q;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/seq_mult_add.sv
// Sequential radix-2 multiply-add: res = q*dvisor + r, one op in flight.
// Optional macro SEQ_MULT_EARLY_EXIT_EN shortens BUSY for small q.
module seq_mult_add
    import seq_mult_add_pkg::*;
#(
    parameter int QUOT_W = QUOT_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input logic           clk,
    input logic           rst,
    seq_mult_add_if.slave bus
);

    localparam int RES_W = res_w(QUOT_W, DIV_W);

    state_e           state_q, state_d;
    logic             rem_ge_div_q, rem_ge_div_d;
    logic             load;
    logic             step;
    logic             last;
    logic [RES_W-1:0] acc;

    assign load = (state_q == IDLE) && bus.in_valid;
    assign step = (state_q == BUSY);

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.res        = acc;
    assign bus.rem_ge_div = rem_ge_div_q;

    seq_mult_add_dp #(
        .QUOT_W (QUOT_W),
        .DIV_W  (DIV_W),
        .RES_W  (RES_W)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .q      (bus.q),
        .dvisor (bus.dvisor),
        .r      (bus.r),
        .acc    (acc),
        .last   (last)
    );

    // Next-state: accept in IDLE, iterate in BUSY, hold result in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flag an out-of-range remainder at accept time.
    always_comb begin
        rem_ge_div_d = rem_ge_div_q;
        if (load) begin
            rem_ge_div_d = (bus.r >= bus.dvisor);
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rem_ge_div_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_ge_div_q <= rem_ge_div_d;
        end
    end

endmodule

// File: tb/tb_seq_mult_add.sv
// Randomized bench for seq_mult_add against an arithmetic reference.
// Also covers stalls, reset mid-op and SEQ_MULT_EARLY_EXIT_EN latency.
module tb_seq_mult_add;

    localparam int QW = 8;
    localparam int DW = 16;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_add_if #(.QUOT_W(QW), .DIV_W(DW)) bus ();

    seq_mult_add #(
        .QUOT_W (QW),
        .DIV_W  (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Edges from accept (inclusive) until out_valid is seen.
    function automatic int exp_lat(input logic [QW-1:0] qq);
        int hi;
        hi = 1;
        for (int i = 0; i < QW; i++) begin
            if (qq[i]) hi = i + 1;
        end
        return EARLY ? 1 + hi : 1 + QW;
    endfunction

    task automatic do_op(input logic [QW-1:0] qq, input logic [DW-1:0] dd,
                         input logic [DW-1:0] rr, input int hold);
        logic [63:0] er;
        logic        er_ge;
        int          edges;
        int          guard;
        er    = 64'(qq) * 64'(dd) + 64'(rr);
        er_ge = (rr >= dd);
        @(negedge clk);
        bus.q         = qq;
        bus.dvisor    = dd;
        bus.r         = rr;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("latency", 64'(edges), 64'(exp_lat(qq)));
        chk("res", 64'(bus.res), er);
        chk("rem_ge_div", 64'(bus.rem_ge_div), 64'(er_ge));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.q        = QW'($urandom);
            bus.dvisor   = DW'($urandom);
            bus.r        = DW'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_res", 64'(bus.res), er);
            chk("hold_rge", 64'(bus.rem_ge_div), 64'(er_ge));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("back_idle", 64'(bus.in_ready), 64'd1);
        chk("out_drop", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        bus.q         = 8'hFF;
        bus.dvisor    = 16'h1357;
        bus.r         = 16'h0042;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res", 64'(bus.res), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_rge", 64'(bus.rem_ge_div), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [QW-1:0] rq;
        logic [DW-1:0] rd;
        logic [DW-1:0] rr;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.q         = '0;
        bus.dvisor    = '0;
        bus.r         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_res", 64'(bus.res), 64'd0);
        chk("reset_rge", 64'(bus.rem_ge_div), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h5A, 16'h1234, 16'h0100, 0);
        do_op(8'hFF, 16'hFFFF, 16'hFFFE, 0);
        do_op(8'hFF, 16'hFFFF, 16'hFFFF, 0);
        do_op(8'h00, 16'h0005, 16'h0007, 0);
        do_op(8'h00, 16'h0000, 16'hBEEF, 0);
        do_op(8'hA7, 16'h0000, 16'h0000, 0);
        do_op(8'h03, 16'h4321, 16'h0011, 0);
        do_op(8'h80, 16'h8001, 16'h7FFF, 0);
        do_op(8'h01, 16'hFFFF, 16'h0000, 0);
        do_op(8'h3C, 16'h00F0, 16'h0F00, 5);
        do_op(8'hC3, 16'h1111, 16'h2222, 0);

        reset_mid_op();
        do_op(8'h5A, 16'h1234, 16'h0100, 0);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       rq = QW'(1) << $urandom_range(0, QW - 1);
                1:       rq = QW'($urandom_range(0, 3));
                default: rq = QW'($urandom);
            endcase
            rd = ($urandom_range(0, 15) == 0) ? '0 : DW'($urandom);
            rr = ($urandom_range(0, 7) == 0) ? rd : DW'($urandom);
            do_op(rq, rd, rr, ($urandom_range(0, 9) == 0) ? 2 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult_add.md
Name: seq_mult_add

Overview:
- Sequential radix-2 shift-add multiply-accumulate for the ISP arithmetic path; the inverse of the array divider.
- Computes res = q*dvisor + r, rebuilding a dividend from quotient, divisor and remainder.
- Used for divide-result checking and for rescale steps that need a multiply.
- Valid/ready handshake on both sides, one operation in flight.

Parameters:
- QUOT_W, 8, quotient operand width (number of iterations).
- DIV_W, 16, divisor and remainder operand width.
- RES_W, QUOT_W+DIV_W, result width (derived, never overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- q  input  QUOT_W  multiplier (quotient).
- dvisor  input  DIV_W  multiplicand (divisor).
- r  input  DIV_W  addend (remainder).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- res  output  RES_W  q*dvisor + r.
- rem_ge_div  output  1  registered flag, r >= dvisor (not a valid remainder for this divisor).

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE, in_ready=1, out_valid=0, res=0, rem_ge_div=0, internal registers 0.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready: latch q, dvisor; load acc={QUOT_W zeros, r}; compute rem_ge_div=(r>=dvisor); cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle, if mplier[0] then acc += dvisor<<cnt, then mplier>>=1 and cnt++. After the cycle with cnt==QUOT_W-1, go to DONE.
  - DONE: out_valid=1; res and rem_ge_div are held stable. On out_ready, go to IDLE.
- in_ready=0 in DONE: no new operand is accepted in the same cycle as an output handshake.
- Latency: out_valid rises QUOT_W+1 clock edges after the accept edge. Throughput is one op per QUOT_W+2 cycles with out_ready held high.
- Width: the max true result (2^QUOT_W-1)(2^DIV_W-1)+(2^DIV_W-1) = 2^QUOT_W*(2^DIV_W-1) < 2^RES_W. There is no overflow for any input, including r >= dvisor. The accumulator is exactly RES_W bits and the addition is unsigned.
- q=0: res=r after the full QUOT_W cycles (base build).
- dvisor=0: res=r, and rem_ge_div=1 for any r.
- Inputs are ignored (no latch) while in_ready=0. Upstream may hold in_valid; it is accepted on return to IDLE.
- Reset mid-operation (BUSY or DONE): abort immediately. Outputs go to their reset values and the operation is lost.

Optional Feature:
- SEQ_MULT_EARLY_EXIT_EN
  - Defined: BUSY exits to DONE after the first cycle in which the shifted mplier becomes zero. Latency = 1 + (index of highest set bit of q, +1), minimum 2 edges (q=0 or q=1 → one BUSY cycle). Results are identical.
  - Undefined: fixed QUOT_W-cycle BUSY as above.

Decomposition:
- Shared package holds:
  - State enum {IDLE, BUSY, DONE}.
  - Default width constants QUOT_W_DEF=8, DIV_W_DEF=16.
  - Function res_w(q,d)=q+d.
- Optional sub-module seq_mult_add_dp: accumulator, mplier shift register and cnt. The top keeps the FSM and handshake.
- A single module is acceptable; target about 150-250 lines.

Test Plan (QUOT_W=8, DIV_W=16, feature off unless stated):
- q=0x5A, dvisor=0x1234, r=0x0100 → res=0x066748, rem_ge_div=0, out_valid exactly 9 edges after accept.
- q=0xFF, dvisor=0xFFFF, r=0xFFFE → res=0xFFFEFF, rem_ge_div=0. Then r=0xFFFF → res=0xFFFF00, rem_ge_div=1, no wrap.
- q=0x00, dvisor=0x0005, r=0x0007 → res=0x000007, rem_ge_div=1; dvisor=0 → res=r.
- out_ready low 5 cycles in DONE → res stable, out_valid held, in_ready=0, a new in_valid is not latched. Release → IDLE, next op accepted the following cycle.
- Assert rst during BUSY cycle 4 → out_valid=0, res=0, in_ready=1 immediately. A subsequent op returns the correct result.
- SEQ_MULT_EARLY_EXIT_EN: q=0x03 → out_valid 3 edges after accept, res correct. q=0x80 → 9 edges. Random 1000 ops versus the reference model, results match the feature-off build.
